// File: rtl/alu_prog_loader.sv
// Program loader for the toy-ALU: streams bytes into the 256x8 program memory, parses
// instruction lengths, then releases and steps the core. Optional: LOADER_SINGLE_STEP_EN.
module alu_prog_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
`ifdef LOADER_SINGLE_STEP_EN
    input  logic              step_req,
`endif
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              core_rst,
    output logic              core_step,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] instr_count,
    output logic [ADDR_W:0]   byte_count
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W-1:0] ADR_ZERO = {ADDR_W{1'b0}};

    // Opcodes with data[5]=1 (length field 2 or 3) carry one immediate byte.
    function automatic logic has_immediate(input logic [DATA_W-1:0] opcode);
        return opcode[5];
    endfunction

    // Published instruction count saturates; a full memory of 1-byte opcodes is 2**ADDR_W.
    function automatic logic [ADDR_W-1:0] sat_count(input logic [ADDR_W:0] cnt);
        return cnt[ADDR_W] ? {ADDR_W{1'b1}} : cnt[ADDR_W-1:0];
    endfunction

    state_t            state_r;
    logic              expect_imm_r;
    logic [ADDR_W:0]   instr_cnt_r;
    logic [ADDR_W:0]   step_cnt_r;

    logic              beat_s;
    logic              imm_next_s;
    logic [ADDR_W:0]   instr_next_s;
    logic [ADDR_W:0]   byte_next_s;
    logic              steps_left_s;
    logic              step_go_s;

    // Beat decode and instruction-length parsing for the byte on the port.
    always_comb begin
        beat_s       = in_valid & in_ready;
        byte_next_s  = byte_count + CNT_ONE;
        steps_left_s = (step_cnt_r != instr_cnt_r);
        if (expect_imm_r) begin
            imm_next_s   = 1'b0;
            instr_next_s = instr_cnt_r;
        end else begin
            imm_next_s   = has_immediate(in_data);
            instr_next_s = instr_cnt_r + CNT_ONE;
        end
`ifdef LOADER_SINGLE_STEP_EN
        step_go_s = steps_left_s & step_req;
`else
        step_go_s = steps_left_s;
`endif
    end

    // Loader FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            expect_imm_r <= 1'b0;
            instr_cnt_r  <= CNT_ZERO;
            step_cnt_r   <= CNT_ZERO;
            in_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= ADR_ZERO;
            mem_wdata    <= {DATA_W{1'b0}};
            core_rst     <= 1'b1;
            core_step    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            instr_count  <= ADR_ZERO;
            byte_count   <= CNT_ZERO;
        end else begin
            mem_we    <= 1'b0;
            core_step <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_r      <= ST_LOAD;
                        expect_imm_r <= 1'b0;
                        instr_cnt_r  <= CNT_ZERO;
                        step_cnt_r   <= CNT_ZERO;
                        instr_count  <= ADR_ZERO;
                        byte_count   <= CNT_ZERO;
                        in_ready     <= 1'b1;
                        core_rst     <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        err          <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (beat_s) begin
                        mem_we       <= 1'b1;
                        mem_addr     <= byte_count[ADDR_W-1:0];
                        mem_wdata    <= in_data;
                        byte_count   <= byte_next_s;
                        expect_imm_r <= imm_next_s;
                        instr_cnt_r  <= instr_next_s;
                        instr_count  <= sat_count(instr_next_s);
                        if (in_last && imm_next_s) begin
                            state_r  <= ST_ERR;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                        end else if (in_last) begin
                            state_r  <= ST_RUN;
                            in_ready <= 1'b0;
                            core_rst <= 1'b0;
                        end else begin
                            in_ready <= ~byte_next_s[ADDR_W];
                        end
                    end else if (in_valid && byte_count[ADDR_W]) begin
                        // Memory full and the source still has data: oversize program.
                        state_r  <= ST_ERR;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        err      <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // First evaluation here is the cycle carrying the final mem_we, so the
                    // first step lands one cycle after the last write.
                    if (!steps_left_s) begin
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (step_go_s) begin
                        core_step  <= 1'b1;
                        step_cnt_r <= step_cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    in_ready <= 1'b0;
                    core_rst <= 1'b1;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    err      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_prog_loader.sv
// Directed self-checking bench for alu_prog_loader; covers the single-step
// variant when LOADER_SINGLE_STEP_EN is defined.
module tb_alu_prog_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
`ifdef LOADER_SINGLE_STEP_EN
    logic       step_req;
`endif
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       core_rst;
    logic       core_step;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] instr_count;
    logic [8:0] byte_count;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int step_cnt = 0;
    int overlap_cnt = 0;
    int step_in_rst = 0;
    int base_we;
    int base_step;
    logic [7:0] img [256];

    alu_prog_loader dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
`ifdef LOADER_SINGLE_STEP_EN
        .step_req(step_req),
`endif
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_rst(core_rst), .core_step(core_step), .busy(busy), .done(done), .err(err),
        .instr_count(instr_count), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    // Passive monitor on the falling edge: memory image and step pulse bookkeeping.
    always @(negedge clk) begin
        if (mem_we) begin
            we_cnt        <= we_cnt + 1;
            img[mem_addr] <= mem_wdata;
        end
        if (core_step) step_cnt <= step_cnt + 1;
        if (core_step && mem_we) overlap_cnt <= overlap_cnt + 1;
        if (core_step && core_rst) step_in_rst <= step_in_rst + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("send_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end();
        for (int i = 0; i < 60 && !done && !err; i++) tick();
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
`ifdef LOADER_SINGLE_STEP_EN
        step_req = 1'b0;
`endif
        tick(); tick();
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_core_rst", {31'b0, core_rst}, 32'd1);
        check("rst_flags", {29'b0, busy, done, err}, 32'd0);
        check("rst_counts", {15'b0, instr_count, byte_count}, 32'd0);
        rst = 1'b0;
        tick();

        // 3-instruction program with a stray in_last and a start inside LOAD.
        base_we = we_cnt; base_step = step_cnt;
        do_start();
        check("t1_busy", {31'b0, busy}, 32'd1);
        in_last = 1'b1;
        tick();
        in_last = 1'b0;
        check("t1_last_no_valid", {23'b0, busy, byte_count}, {23'b0, 1'b1, 9'd0});
        send(8'h00, 1'b0);
        start = 1'b1;
        send(8'h14, 1'b0);
        start = 1'b0;
        send(8'h21, 1'b0);
        send(8'h05, 1'b1);
        check("t1_core_rst_run", {31'b0, core_rst}, 32'd0);
        wait_end();
        check("t1_done", {29'b0, busy, done, err}, 32'd2);
        check("t1_writes", we_cnt - base_we, 32'd4);
        check("t1_image", {img[0], img[1], img[2], img[3]}, 32'h00142105);
        check("t1_instr_count", {24'b0, instr_count}, 32'd3);
        check("t1_byte_count", {23'b0, byte_count}, 32'd4);
        check("t1_steps", step_cnt - base_step, 32'd3);
        check("t1_core_rst_done", {31'b0, core_rst}, 32'd0);

        // Truncated program: opcode needs an immediate but is last.
        base_step = step_cnt;
        do_start();
        check("t2_core_rst_load", {31'b0, core_rst}, 32'd1);
        send(8'h25, 1'b1);
        check("t2_err", {29'b0, busy, done, err}, 32'd1);
        check("t2_core_rst", {31'b0, core_rst}, 32'd1);
        check("t2_in_ready", {31'b0, in_ready}, 32'd0);
        for (int i = 0; i < 5; i++) tick();
        check("t2_no_steps", step_cnt - base_step, 32'd0);
        check("t2_counts", {15'b0, instr_count, byte_count}, {15'b0, 8'd1, 9'd1});

        // Oversize program: 256 accepted beats, then a 257th byte with in_ready low.
        base_we = we_cnt;
        do_start();
        check("t3_err_cleared", {31'b0, err}, 32'd0);
        for (int i = 0; i < 256; i++) send(8'h00, 1'b0);
        check("t3_in_ready_full", {31'b0, in_ready}, 32'd0);
        check("t3_byte_count", {23'b0, byte_count}, 32'd256);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t3_err", {29'b0, busy, done, err}, 32'd1);
        tick();
        check("t3_writes", we_cnt - base_we, 32'd256);
        check("t3_last_addr", {24'b0, mem_addr}, 32'd255);

        // Reset in the middle of a load.
        do_start();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_flags", {26'b0, in_ready, mem_we, core_step, busy, done, err}, 32'd0);
        check("t4_core_rst", {31'b0, core_rst}, 32'd1);
        check("t4_counts", {15'b0, instr_count, byte_count}, 32'd0);

        // One 2-byte instruction to reach DONE, then reload with a single 1-byte op.
        base_step = step_cnt;
        do_start();
        send(8'h30, 1'b0);
        send(8'h07, 1'b1);
        wait_end();
        check("t5a_done", {29'b0, busy, done, err}, 32'd2);
        check("t5a_steps", step_cnt - base_step, 32'd1);
        base_step = step_cnt;
        do_start();
        check("t5_reload_core_rst", {30'b0, core_rst, done}, 32'd2);
        send(8'h0F, 1'b1);
        wait_end();
        check("t5_done", {29'b0, busy, done, err}, 32'd2);
        check("t5_counts", {15'b0, instr_count, byte_count}, {15'b0, 8'd1, 9'd1});
        check("t5_steps", step_cnt - base_step, 32'd1);
        check("t5_image", {24'b0, img[0]}, 32'h0F);

`ifdef LOADER_SINGLE_STEP_EN
        // Steps are issued only on request, one cycle after each step_req.
        base_step = step_cnt;
        do_start();
        send(8'h00, 1'b0);
        send(8'h10, 1'b0);
        send(8'h01, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        check("ss_no_free_run", step_cnt - base_step, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step_req = 1'b1;
            tick();
            step_req = 1'b0;
            check("ss_step_high", {31'b0, core_step}, 32'd1);
            tick();
            check("ss_step_low", {31'b0, core_step}, 32'd0);
            for (int i = 0; i < 3; i++) tick();
        end
        wait_end();
        check("ss_done", {29'b0, busy, done, err}, 32'd2);
        check("ss_steps", step_cnt - base_step, 32'd3);
`endif

        check("no_step_during_write", overlap_cnt, 32'd0);
        check("no_step_in_core_rst", step_in_rst, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
